// File: rtl/c_tile_buf_mp.sv
// c_tile_buf_mp: captures an MxN C tile into a shadow, drains it row by row into storage, serves NCH round-robin read channels with single/burst reads.
// Optional macro C_TILE_BUF_PARITY_EN adds per-word even parity storage and the rd_perr output.
module c_tile_buf_mp #(
  parameter int M = 8,
  parameter int N = 8,
  parameter int DATA_W = 32,
  parameter int NCH = 2,
  localparam int ROW_W = (M <= 1) ? 1 : $clog2(M),
  localparam int COL_W = (N <= 1) ? 1 : $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cap_start,
  input  logic [M*N*DATA_W-1:0]   c_in_flat,
  output logic                    cap_ready,
  output logic                    cap_drop,
  output logic                    busy,
  output logic                    C_valid,
  input  logic [NCH-1:0]          rd_req,
  input  logic [NCH-1:0]          rd_burst,
  input  logic [NCH*ROW_W-1:0]    rd_row,
  input  logic [NCH*COL_W-1:0]    rd_col,
  output logic [NCH-1:0]          rd_gnt,
  output logic [NCH*DATA_W-1:0]   rd_rdata,
  output logic [NCH-1:0]          rd_rvalid,
  output logic [NCH-1:0]          rd_last
`ifdef C_TILE_BUF_PARITY_EN
  ,
  output logic [NCH-1:0]          rd_perr
`endif
);
  localparam int CH_W = (NCH <= 1) ? 1 : $clog2(NCH);
  localparam int AW = (M * N <= 1) ? 1 : $clog2(M * N);
  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_READY} state_t;
  state_t                  r_state;
  logic [ROW_W-1:0]        r_drow;
  logic [M*N*DATA_W-1:0]   r_shadow;
  logic [DATA_W-1:0]       r_mem [M*N];
`ifdef C_TILE_BUF_PARITY_EN
  logic                    r_par [M*N];
`endif
  logic                    r_lock;
  logic [CH_W-1:0]         r_lch;
  logic [CH_W-1:0]         r_ptr;
  logic [ROW_W-1:0]        r_brow;
  logic [COL_W-1:0]        r_bcol;
  logic                    w_arb_en;
  logic                    w_any;
  logic [CH_W-1:0]         w_gch;
  logic [ROW_W-1:0]        w_grow;
  logic [COL_W-1:0]        w_gcol;
  logic                    w_gbur;
  logic                    w_acc;
  logic                    w_ren;
  logic [CH_W-1:0]         w_rch;
  logic [ROW_W-1:0]        w_rrow;
  logic [COL_W-1:0]        w_rcol;
  logic                    w_rlast;
  logic [AW-1:0]           w_ridx;

  assign w_arb_en  = (r_state == S_READY) && C_valid && !r_lock;
  assign cap_ready = (r_state != S_DRAIN) && !r_lock && !(w_arb_en && |rd_req);
  assign cap_drop  = cap_start && !cap_ready;
  assign w_acc     = cap_start && cap_ready;

  // round-robin pick: search upward from the pointer, first requester wins
  always_comb begin
    w_any  = 1'b0;
    w_gch  = '0;
    rd_gnt = '0;
    for (int k = 0; k < NCH; k++)
      if (!w_any && rd_req[(int'(r_ptr) + k) % NCH]) begin
        w_any = 1'b1;
        w_gch = CH_W'((int'(r_ptr) + k) % NCH);
      end
    w_any = w_any && w_arb_en;
    rd_gnt[w_gch] = w_any;
  end

  assign w_grow  = rd_row[w_gch*ROW_W +: ROW_W];
  assign w_gcol  = rd_col[w_gch*COL_W +: COL_W];
  assign w_gbur  = rd_burst[w_gch];
  assign w_ren   = w_any || r_lock;
  assign w_rch   = w_any ? w_gch : r_lch;
  assign w_rrow  = w_any ? w_grow : r_brow;
  assign w_rcol  = w_any ? w_gcol : r_bcol;
  assign w_rlast = w_any ? (!w_gbur || w_gcol == COL_W'(N - 1)) : (r_bcol == COL_W'(N - 1));
  assign w_ridx  = AW'(int'(w_rrow) * N + int'(w_rcol));

  // capture/drain control: accept into DRAIN, one row per cycle, then READY
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_drow  <= '0;
      busy    <= 1'b0;
      C_valid <= 1'b0;
    end else if (w_acc) begin
      r_state <= S_DRAIN;
      r_drow  <= '0;
      busy    <= 1'b1;
      C_valid <= 1'b0;
    end else if (r_state == S_DRAIN) begin
      r_drow <= r_drow + 1'b1;
      if (r_drow == ROW_W'(M - 1)) begin
        r_state <= S_READY;
        busy    <= 1'b0;
        C_valid <= 1'b1;
      end
    end

  // shadow latch and row-wise storage write; storage is deliberately unreset
  always_ff @(posedge clk) begin
    if (w_acc) r_shadow <= c_in_flat;
    if (r_state == S_DRAIN)
      for (int j = 0; j < N; j++) begin
        r_mem[AW'(int'(r_drow) * N + j)] <= r_shadow[(int'(r_drow) * N + j) * DATA_W +: DATA_W];
`ifdef C_TILE_BUF_PARITY_EN
        r_par[AW'(int'(r_drow) * N + j)] <= ^r_shadow[(int'(r_drow) * N + j) * DATA_W +: DATA_W];
`endif
      end
  end

  // read datapath: grant or burst continuation produces one word next cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_lock    <= 1'b0;
      r_lch     <= '0;
      r_ptr     <= '0;
      r_brow    <= '0;
      r_bcol    <= '0;
      rd_rvalid <= '0;
      rd_last   <= '0;
      rd_rdata  <= '0;
`ifdef C_TILE_BUF_PARITY_EN
      rd_perr   <= '0;
`endif
    end else begin
      rd_rvalid <= '0;
      rd_last   <= '0;
`ifdef C_TILE_BUF_PARITY_EN
      rd_perr   <= '0;
`endif
      if (w_any) begin
        r_ptr  <= (w_gch == CH_W'(NCH - 1)) ? '0 : w_gch + 1'b1;
        r_lock <= w_gbur && (w_gcol != COL_W'(N - 1));
        r_lch  <= w_gch;
        r_brow <= w_grow;
        r_bcol <= w_gcol + 1'b1;
      end else if (r_lock) begin
        r_bcol <= r_bcol + 1'b1;
        if (r_bcol == COL_W'(N - 1)) r_lock <= 1'b0;
      end
      if (w_ren) begin
        rd_rvalid[w_rch] <= 1'b1;
        rd_last[w_rch]   <= w_rlast;
        rd_rdata[w_rch*DATA_W +: DATA_W] <= r_mem[w_ridx];
`ifdef C_TILE_BUF_PARITY_EN
        rd_perr[w_rch]   <= (^r_mem[w_ridx]) ^ r_par[w_ridx];
`endif
      end
    end
endmodule

// File: tb/tb_c_tile_buf_mp.sv
// tb_c_tile_buf_mp: directed-vector bench for c_tile_buf_mp (M=N=8, DATA_W=32, NCH=2).
module tb_c_tile_buf_mp;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cap_start = 1'b0;
  logic [2047:0] c_in_flat = '0;
  logic          cap_ready, cap_drop, busy, C_valid;
  logic [1:0]    rd_req = '0, rd_burst = '0;
  logic [5:0]    rd_row = '0, rd_col = '0;
  logic [1:0]    rd_gnt, rd_rvalid, rd_last;
  logic [63:0]   rd_rdata;
`ifdef C_TILE_BUF_PARITY_EN
  logic [1:0]    rd_perr;
  logic [1:0]    pe;
`endif
  logic [31:0]   ta [64];
  logic [2047:0] fa, fb;
  int            total = 0, bad = 0;

  c_tile_buf_mp dut (
    .clk(clk), .rst(rst), .cap_start(cap_start), .c_in_flat(c_in_flat),
    .cap_ready(cap_ready), .cap_drop(cap_drop), .busy(busy), .C_valid(C_valid),
    .rd_req(rd_req), .rd_burst(rd_burst), .rd_row(rd_row), .rd_col(rd_col),
    .rd_gnt(rd_gnt), .rd_rdata(rd_rdata), .rd_rvalid(rd_rvalid), .rd_last(rd_last)
`ifdef C_TILE_BUF_PARITY_EN
    , .rd_perr(rd_perr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rd1(input int ch, input int row, input int col, input logic [31:0] exp);
    rd_req = '0;
    rd_req[ch] = 1'b1;
    rd_burst = '0;
    rd_row[ch*3 +: 3] = row[2:0];
    rd_col[ch*3 +: 3] = col[2:0];
    @(negedge clk);
    chk("rd1_gnt", rd_gnt, 64'(1 << ch));
    @(posedge clk); #1;
    rd_req = '0;
    @(negedge clk);
    chk("rd1_vl", {rd_rvalid, rd_last}, {2'(1 << ch), 2'(1 << ch)});
    chk("rd1_data", rd_rdata[ch*32 +: 32], exp);
`ifdef C_TILE_BUF_PARITY_EN
    pe = rd_perr;
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ta[i] = 32'h4000_0000 | ((i / 8) << 8) | (i % 8);
    ta[0]  = 32'h4140_0000;
    ta[63] = 32'h4140_0000;
    ta[12] = 32'h4134_0000;
    ta[13] = 32'h4140_0000;
    ta[14] = 32'h4110_0000;
    ta[15] = 32'h4120_0000;
    for (int i = 0; i < 64; i++) begin
      fa[i*32 +: 32] = ta[i];
      fb[i*32 +: 32] = ~ta[i];
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {busy, C_valid, cap_ready, cap_drop, rd_gnt, rd_rvalid, rd_last}, 64'b0010_0000_00);
    chk("rst_rdata", rd_rdata, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    rd_req = 2'b11;
    @(negedge clk);
    chk("idle_nogrant", rd_gnt, 64'h0);
    @(posedge clk); #1;
    rd_req = '0;
    cap_start = 1'b1;
    c_in_flat = fa;
    @(negedge clk);
    chk("cap_accept", {cap_ready, cap_drop}, 64'b10);
    @(posedge clk); #1;
    cap_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        cap_start = 1'b1;
        c_in_flat = fb;
      end
      @(negedge clk);
      chk("drain_busy", {busy, C_valid}, 64'b10);
      if (k == 3) chk("drain_drop", {cap_ready, cap_drop}, 64'b01);
      @(posedge clk); #1;
      cap_start = 1'b0;
    end
    @(negedge clk);
    chk("valid_c9", {busy, C_valid, cap_ready}, 64'b011);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) rd1(0, i, j, ta[i*8 + j]);
    rd_req = 2'b01;
    rd_burst = 2'b01;
    rd_row[2:0] = 3'd1;
    rd_col[2:0] = 3'd4;
    @(negedge clk);
    chk("burst_gnt", rd_gnt, 64'b01);
    @(posedge clk); #1;
    rd_req = '0;
    rd_burst = '0;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      chk("burst_vl", {rd_rvalid, rd_last}, {2'b01, (w == 3) ? 2'b01 : 2'b00});
      chk("burst_data", rd_rdata[31:0], ta[12 + w]);
      if (w == 1) chk("burst_noready", cap_ready, 64'h0);
      if (w == 3) chk("burst_ready", cap_ready, 64'h1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("burst_end", rd_rvalid, 64'h0);
    @(posedge clk); #1;
    rd1(1, 7, 7, 32'h4140_0000);
    rd_req = 2'b11;
    rd_row = {3'd5, 3'd2};
    rd_col = {3'd6, 3'd3};
    cap_start = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("rr_gnt", rd_gnt, (t % 2 == 0) ? 64'b01 : 64'b10);
      chk("rr_rvalid", {rd_rvalid, rd_last}, (t == 0) ? 64'h0 : ((t % 2 == 1) ? 64'b0101 : 64'b1010));
      if (t == 0) chk("cap_vs_read", {cap_ready, cap_drop}, 64'b01);
      if (t == 1) chk("rr_data0", rd_rdata[31:0], ta[2*8 + 3]);
      @(posedge clk); #1;
      cap_start = 1'b0;
    end
    rd_req = '0;
    @(negedge clk);
    chk("rr_tail", {rd_rvalid, rd_last}, 64'b1010);
    chk("rr_data1", rd_rdata[63:32], ta[5*8 + 6]);
    @(posedge clk); #1;
    rd_req = 2'b10;
    rd_burst = 2'b10;
    rd_row[5:3] = 3'd0;
    rd_col[5:3] = 3'd0;
    @(negedge clk);
    chk("rb_gnt", rd_gnt, 64'b10);
    @(posedge clk); #1;
    rd_req = '0;
    rd_burst = '0;
    @(negedge clk);
    chk("rb_w0", rd_rdata[63:32], ta[0]);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rb_w1", {rd_rvalid, rd_last}, 64'b1000);
    #1;
    rst = 1'b1;
    #1;
    chk("rb_rst_ctl", {busy, C_valid, cap_ready, cap_drop, rd_gnt, rd_rvalid, rd_last}, 64'b0010_0000_00);
    chk("rb_rst_data", rd_rdata, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rb_aborted", rd_rvalid, 64'h0);
    @(posedge clk); #1;
    cap_start = 1'b1;
    c_in_flat = fa;
    @(negedge clk);
    chk("recap_accept", cap_ready, 64'h1);
    @(posedge clk); #1;
    cap_start = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("recap_valid", C_valid, 64'h1);
    @(posedge clk); #1;
`ifdef C_TILE_BUF_PARITY_EN
    dut.r_mem[10] = dut.r_mem[10] ^ 32'h0000_0001;
    rd1(0, 1, 2, ta[10] ^ 32'h1);
    chk("perr_hit", pe, 64'b01);
    rd1(0, 1, 3, ta[11]);
    chk("perr_clean", pe, 64'b00);
`else
    rd1(0, 1, 2, ta[10]);
`endif
    rd1(1, 0, 0, ta[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/c_tile_buf_mp.md
C_TILE_BUF_MP -- requirements
Module: c_tile_buf_mp

Interface
- REQ-001 SHALL have parameter M, default 8: C tile rows.
- REQ-002 SHALL have parameter N, default 8: C tile columns.
- REQ-003 SHALL have parameter DATA_W, default 32: word width in bits (FP32 bit pattern, never interpreted).
- REQ-004 SHALL have parameter NCH, default 2: number of independent read channels.
- REQ-005 SHALL have derived parameters ROW_W = (M<=1)?1:clog2(M) and COL_W = (N<=1)?1:clog2(N).
- REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
- REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-008 SHALL have port cap_start, input, 1 bit: one-cycle capture request.
- REQ-009 SHALL have port c_in_flat, input, M*N*DATA_W bits: word (i,j) at bits [(i*N+j)*DATA_W +: DATA_W].
- REQ-010 SHALL have port cap_ready, output, 1 bit: capture would be accepted this cycle.
- REQ-011 SHALL have port cap_drop, output, 1 bit: one-cycle pulse when cap_start arrives with cap_ready low.
- REQ-012 SHALL have port busy, output, 1 bit: high while draining.
- REQ-013 SHALL have port C_valid, output, 1 bit: stored tile complete and readable.
- REQ-014 SHALL have port rd_req, input, NCH bits: per-channel request, held until granted.
- REQ-015 SHALL have port rd_burst, input, NCH bits: read from rd_col through column N-1.
- REQ-016 SHALL have ports rd_row (NCH*ROW_W) and rd_col (NCH*COL_W), inputs: per-channel start address.
- REQ-017 SHALL have port rd_gnt, output, NCH bits: one-cycle acceptance pulse.
- REQ-018 SHALL have port rd_rdata, output, NCH*DATA_W bits: per-channel read data.
- REQ-019 SHALL have ports rd_rvalid and rd_last, outputs, NCH bits each: data valid, and final word of a transfer.

Function
- REQ-020 SHALL implement FSM IDLE -> DRAIN -> READY; a cap_start accepted in IDLE or READY latches c_in_flat into a shadow register and enters DRAIN.
- REQ-021 SHALL write shadow row r into storage on DRAIN cycle r, r = 0..M-1, then enter READY with C_valid=1 on the following cycle.
- REQ-022 SHALL hold C_valid low from the capture-accept cycle until the drain completes.
- REQ-023 SHALL hold cap_ready=0 while in DRAIN or while any read transfer is in flight.
- REQ-024 SHALL ignore cap_start when cap_ready=0 and pulse cap_drop for one cycle.
- REQ-025 SHALL grant reads only in READY, one channel per cycle, using round-robin priority starting after the last granted channel; after reset, channel 0 has priority.
- REQ-026 SHALL return single-word data with fixed latency 1: rd_rvalid and rd_last for the granted channel are high in the cycle after rd_gnt.
- REQ-027 SHALL, for a burst, lock the arbiter to that channel and return N-rd_col words on consecutive cycles starting one cycle after grant; rd_last is set on the column N-1 word; arbitration resumes in the rd_last cycle.
- REQ-028 SHALL hold rd_rdata stable for each channel until that channel's next rd_rvalid.
- REQ-029 SHALL drop capture and read requests made in the same READY cycle in favour of the read: cap_ready is 0 and cap_drop pulses.

Reset
- REQ-030 SHALL, on rst, immediately force state IDLE and clear busy, C_valid, cap_drop, rd_gnt, rd_rvalid, rd_last and rd_rdata to 0, set cap_ready=1, reset the round-robin pointer to channel 0, and abort any drain or burst.
- REQ-031 SHALL leave storage contents unreset; reads are only granted when C_valid=1.

Configuration
- REQ-032 SHALL, with macro C_TILE_BUF_PARITY_EN defined, store an even-parity bit per word, add output rd_perr (NCH bits) valid with rd_rvalid, and flag a mismatch on read.
- REQ-033 SHALL, without C_TILE_BUF_PARITY_EN, omit the parity storage and the rd_perr port entirely.

Verification
- REQ-034 SHALL cover the capture-to-valid path: capture a tile with C[0][0]=0x41400000 and C[7][7]=0x41400000 -> busy for 8 cycles, C_valid high on cycle 9 after accept, and all 64 single reads match.
- REQ-035 SHALL cover a burst read: ch0 burst at row 1, col 4 -> 4 words 0x41340000, 0x41400000, 0x41100000, 0x41200000 on consecutive cycles, with rd_last on the 4th.
- REQ-036 SHALL cover simultaneous channel requests: both channels request every cycle -> grants alternate 0,1,0,1 and each rvalid follows its grant by 1 cycle.
- REQ-037 SHALL cover capture during DRAIN: cap_start during DRAIN -> cap_drop pulses and stored data equals the first tile.
- REQ-038 SHALL cover reset mid-burst: rst asserted at the 2nd burst word -> outputs cleared immediately, C_valid=0, cap_ready=1.
- REQ-039 SHALL cover parity with C_TILE_BUF_PARITY_EN: force a stored bit flip -> rd_perr=1 on that read only.
